// File: rtl/writeback_arbiter_if.sv
// Register-file write-back bundle: ALU and long-latency result handshakes,
// pending-scoreboard mark/query, and the registered register-file write port.
interface writeback_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            mark_valid;
  logic [4:0]      mark_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [CW-1:0]   fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mark_valid, mark_rd, rs1, rs2,
    input  alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_we, rf_rd, rf_wd, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mark_valid, mark_rd, rs1, rs2,
    output alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_we, rf_rd, rf_wd, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Single writer of the register-file write port: arbitrates ALU results against a
// buffered long-latency result FIFO and tracks pending long-latency destinations.
module writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  writeback_arbiter_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } result_t;

  result_t         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pending_q, pending_d;
  logic            rf_we_q, rf_we_d;
  logic            from_fifo_q, from_fifo_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  logic    full, empty, push, pop, alu_fire;
  result_t winner;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push     = wb.lsu_valid && !full;
    // A full FIFO must drain before the ALU can stall it forever.
    pop      = full || (!wb.alu_valid && !empty);
    alu_fire = wb.alu_valid && !full;
    winner   = pop ? fifo_mem[rd_ptr_q] : '{rd: wb.alu_rd, data: wb.alu_data};

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // x0 results are consumed but never written; address/data then hold like idle.
    rf_we_d     = (pop || alu_fire) && (winner.rd != 5'd0);
    from_fifo_d = pop;
    rf_rd_d     = rf_we_d ? winner.rd   : rf_rd_q;
    rf_wd_d     = rf_we_d ? winner.data : rf_wd_q;

    // Clear is applied before set so a same-edge mark of the same register wins.
    pending_d = pending_q;
    if (rf_we_q && from_fifo_q) pending_d[rf_rd_q] = 1'b0;
    if (wb.mark_valid && (wb.mark_rd != 5'd0)) pending_d[wb.mark_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      rf_we_q     <= 1'b0;
      from_fifo_q <= 1'b0;
      rf_rd_q     <= '0;
      rf_wd_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      rf_we_q     <= rf_we_d;
      from_fifo_q <= from_fifo_d;
      rf_rd_q     <= rf_rd_d;
      rf_wd_q     <= rf_wd_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; entries are only readable
  // through the pointers and count, which are.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{rd: wb.lsu_rd, data: wb.lsu_data};
  end

  assign wb.alu_ready  = !full;
  assign wb.lsu_ready  = !full;
  assign wb.rs1_busy   = (wb.rs1 != 5'd0) && pending_q[wb.rs1];
  assign wb.rs2_busy   = (wb.rs2 != 5'd0) && pending_q[wb.rs2];
  assign wb.rf_we      = rf_we_q;
  assign wb.rf_rd      = rf_rd_q;
  assign wb.rf_wd      = rf_wd_q;
  assign wb.fifo_count = count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scenario bench for writeback_arbiter: a behavioural queue model predicts each
// cycle's register-file write and is compared after every clock edge.
module tb_writeback_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) bus ();
  writeback_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } res_t;

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
    logic            fifo;
  } wr_t;

  res_t        mq[$];
  wr_t         exp_q[$];
  wr_t         last_wr = '0;
  logic [31:0] pend    = '0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.mark_valid = 1'b0; bus.mark_rd = '0;
  endtask

  // Predicts this cycle's winner, advances one clock, then compares the DUT.
  task automatic cycle();
    wr_t         e;
    res_t        win;
    logic        have_win, from_fifo, full;
    logic [31:0] nxt_pend;
    #1;
    full = (mq.size() == DEPTH);
    if (rst) begin
      checks++;
      if (bus.alu_ready !== !full || bus.lsu_ready !== !full) begin
        errors++;
        $display("FAIL ready: alu_ready=%b lsu_ready=%b required %b", bus.alu_ready, bus.lsu_ready, !full);
      end
    end
    have_win = 1'b0; from_fifo = 1'b0; win = '0;
    if (full) begin
      win = mq.pop_front(); have_win = 1'b1; from_fifo = 1'b1;
    end else if (bus.alu_valid) begin
      win = '{bus.alu_rd, bus.alu_data}; have_win = 1'b1;
    end else if (mq.size() != 0) begin
      win = mq.pop_front(); have_win = 1'b1; from_fifo = 1'b1;
    end
    if (bus.lsu_valid && !full) mq.push_back('{bus.lsu_rd, bus.lsu_data});
    nxt_pend = pend;
    if (last_wr.we && last_wr.fifo) nxt_pend[last_wr.rd] = 1'b0;
    if (bus.mark_valid && bus.mark_rd != 0) nxt_pend[bus.mark_rd] = 1'b1;
    nxt_pend[0] = 1'b0;
    e = last_wr; e.we = 1'b0; e.fifo = 1'b0;
    if (have_win && win.rd != 0) e = '{1'b1, win.rd, win.wd, from_fifo};
    if (!rst) begin
      mq.delete(); nxt_pend = '0; e = '0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    pend = nxt_pend;
    last_wr = e;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (bus.rf_we !== e.we || bus.rf_rd !== e.rd || bus.rf_wd !== e.wd) begin
      errors++;
      $display("FAIL rf_write: got we=%b rd=%0d wd=%h required we=%b rd=%0d wd=%h",
               bus.rf_we, bus.rf_rd, bus.rf_wd, e.we, e.rd, e.wd);
    end
    checks++;
    if (bus.fifo_count !== CW'(mq.size())) begin
      errors++;
      $display("FAIL fifo_count: got %0d required %0d", bus.fifo_count, mq.size());
    end
    checks++;
    if (bus.rs1_busy !== pend[bus.rs1] || bus.rs2_busy !== pend[bus.rs2]) begin
      errors++;
      $display("FAIL busy: got rs1_busy=%b rs2_busy=%b required %b %b",
               bus.rs1_busy, bus.rs2_busy, pend[bus.rs1], pend[bus.rs2]);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); bus.rs1 = 5'd5; bus.rs2 = 5'd7;
    rst = 1'b0;
    cycle(); cycle();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wd !== '0 || bus.fifo_count !== '0) begin
      errors++;
      $display("FAIL reset_state: we=%b rd=%0d wd=%h count=%0d required 0 0 0 0",
               bus.rf_we, bus.rf_rd, bus.rf_wd, bus.fifo_count);
    end
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b %b required 0 0", bus.rs1_busy, bus.rs2_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b %b required 1 1", bus.alu_ready, bus.lsu_ready);
    end
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write: we=%b rd=%0d wd=%h required 1 5 deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wd);
    end
    cycle();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL idle_hold: we=%b rd=%0d wd=%h required 0 5 deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wd);
    end
  endtask

  task automatic test_scoreboard();
    bus.rs1 = 5'd7;
    bus.mark_valid = 1'b1; bus.mark_rd = 5'd7;
    cycle();
    idle_inputs();
    checks++;
    if (bus.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL mark_busy: got %b required 1", bus.rs1_busy);
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h1234;
    cycle();
    idle_inputs();
    cycle();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wd !== 32'h1234 || bus.rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL lsu_write: we=%b rd=%0d wd=%h busy=%b required 1 7 1234 1",
               bus.rf_we, bus.rf_rd, bus.rf_wd, bus.rs1_busy);
    end
    cycle();
    checks++;
    if (bus.rs1_busy !== 1'b0) begin
      errors++; $display("FAIL busy_clear: got %b required 0", bus.rs1_busy);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ready: got %b required 1", bus.alu_ready);
    end
    cycle();
    idle_inputs();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_write: rf_we=%b required 0", bus.rf_we);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + i); bus.alu_data = 32'hA0 + i;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(20 + i); bus.lsu_data = 32'hB0 + i;
      cycle();
    end
    bus.lsu_valid = 1'b0;
    bus.alu_rd = 5'd14; bus.alu_data = 32'hA4;
    checks++;
    if (bus.fifo_count !== CW'(4) || bus.lsu_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d lsu_ready=%b alu_ready=%b required 4 0 0",
               bus.fifo_count, bus.lsu_ready, bus.alu_ready);
    end
    cycle();
    checks++;
    if (bus.rf_rd !== 5'd20 || bus.rf_wd !== 32'hB0) begin
      errors++; $display("FAIL full_pop: rd=%0d wd=%h required 20 b0", bus.rf_rd, bus.rf_wd);
    end
    cycle();
    checks++;
    if (bus.rf_rd !== 5'd14 || bus.rf_wd !== 32'hA4) begin
      errors++; $display("FAIL alu_resume: rd=%0d wd=%h required 14 a4", bus.rf_rd, bus.rf_wd);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (bus.rf_rd !== 5'd23 || bus.fifo_count !== '0) begin
      errors++; $display("FAIL drain: rd=%0d count=%0d required 23 0", bus.rf_rd, bus.fifo_count);
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd24; bus.lsu_data = 32'hC0;
    cycle();
    bus.lsu_rd = 5'd25; bus.lsu_data = 32'hC1;
    cycle();
    idle_inputs();
    checks++;
    if (bus.fifo_count !== CW'(1) || bus.rf_rd !== 5'd24) begin
      errors++; $display("FAIL push_pop: count=%0d rd=%0d required 1 24", bus.fifo_count, bus.rf_rd);
    end
    cycle(); cycle();
  endtask

  task automatic test_set_wins();
    bus.rs2 = 5'd9;
    bus.mark_valid = 1'b1; bus.mark_rd = 5'd9;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    cycle();
    idle_inputs();
    cycle();
    bus.mark_valid = 1'b1; bus.mark_rd = 5'd9;
    cycle();
    idle_inputs();
    checks++;
    if (bus.rs2_busy !== 1'b1) begin
      errors++; $display("FAIL set_wins: rs2_busy=%b required 1", bus.rs2_busy);
    end
    cycle();
    checks++;
    if (bus.rs2_busy !== 1'b1) begin
      errors++; $display("FAIL set_holds: rs2_busy=%b required 1", bus.rs2_busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.rs1 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(1 + i); bus.alu_data = 32'h10 + i;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(3 + i); bus.lsu_data = 32'h30 + i;
      bus.mark_valid = 1'b1; bus.mark_rd = 5'(3 + i);
      cycle();
    end
    idle_inputs();
    checks++;
    if (bus.fifo_count !== CW'(3) || bus.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL mid_fill: count=%0d busy=%b required 3 1", bus.fifo_count, bus.rs1_busy);
    end
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    checks++;
    if (bus.fifo_count !== '0 || bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d we=%b rd=%0d required 0 0 0", bus.fifo_count, bus.rf_we, bus.rf_rd);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.rf_we !== 1'b0) begin
        errors++; $display("FAIL post_reset_we: cycle %0d rf_we=%b required 0", i, bus.rf_we);
      end
    end
    for (int r = 0; r < 32; r++) begin
      bus.rs1 = 5'(r); bus.rs2 = 5'(31 - r);
      #1;
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_busy: x%0d busy=%b %b required 0 0", r, bus.rs1_busy, bus.rs2_busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_scoreboard();
    test_back_to_back();
    test_set_wins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
